pc_sequencer: RTL and testbench

- Multi-cycle program-counter controller for the 16-bit core.
- Owns the PC register and sequences instruction fetch through a request/acknowledge handshake.
- Resolves next-PC at the end of each instruction: sequential, branch, call or return.
- Drives the PC-select mux control (PCSrc) plus both mux data legs, and keeps a small return-address stack for call/return.

---
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Groups the fetch handshake, control-unit request lines, PC-select mux
//   legs and stack status flags of the program-counter sequencer.
//
//   master : the sequencer (drives FetchReq/FetchAddr/InstrReady, mux legs,
//            PC and flags; receives FetchAck, Done, Branch, Call, Ret, Target)
//   slave  : memory / control unit side (the reverse directions)
interface pc_sequencer_if;
  logic        FetchReq;
  logic [15:0] FetchAddr;
  logic        FetchAck;
  logic        InstrReady;
  logic        Done;
  logic        Branch;
  logic        Call;
  logic        Ret;
  logic [15:0] Target;
  logic        PCSrc;
  logic [15:0] SeqPC;
  logic [15:0] RedirPC;
  logic [15:0] PC;
  logic        RasOverflow;
  logic        RasUnderflow;

  modport master (
    output FetchReq, FetchAddr, InstrReady, PCSrc, SeqPC, RedirPC, PC,
           RasOverflow, RasUnderflow,
    input  FetchAck, Done, Branch, Call, Ret, Target
  );

  modport slave (
    input  FetchReq, FetchAddr, InstrReady, PCSrc, SeqPC, RedirPC, PC,
           RasOverflow, RasUnderflow,
    output FetchAck, Done, Branch, Call, Ret, Target
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multi-cycle program-counter controller for the 16-bit core. Owns the PC,
//   sequences instruction fetch through a request/acknowledge handshake,
//   resolves next-PC (sequential / branch / call / return) at the end of each
//   instruction and keeps a small circular return-address stack.
//
// Ports:
//   CLK    in  system clock, rising edge
//   Reset  in  synchronous active-high reset
//   bus    pc_sequencer_if.master
//     FetchReq/FetchAddr/FetchAck  instruction fetch handshake
//     InstrReady                   instruction latched, executing
//     Done/Branch/Call/Ret/Target  end-of-instruction request from control
//     PCSrc/SeqPC/RedirPC          PC-select mux control and both data legs
//     PC                           current program counter
//     RasOverflow/RasUnderflow     sticky stack error flags
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int unsigned PC_INCR      = 2,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic           CLK,
  input  logic           Reset,
  pc_sequencer_if.master bus
);

  localparam int unsigned SPW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(RAS_DEPTH + 1);
  localparam logic [15:0] LP_INCR  = 16'(PC_INCR);
  localparam logic [CW-1:0] LP_FULL = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_pc;
  logic [SPW-1:0]  r_sp;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_stack [RAS_DEPTH];
  logic            r_ovf;
  logic            r_unf;

  logic [15:0]     w_seq_pc;
  logic [15:0]     w_redir_pc;
  logic [15:0]     w_top;
  logic [SPW-1:0]  w_sp_dec;
  logic            w_pcsrc;
  logic            w_exec_done;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_set_ovf;
  logic            w_set_unf;
  logic            w_fetch_req;
  logic            w_instr_ready;

  assign w_seq_pc    = r_pc + LP_INCR;          // wraps modulo 2^16
  assign w_sp_dec    = r_sp - SPW'(1);
  assign w_top       = r_stack[w_sp_dec];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == LP_FULL);
  assign w_exec_done = (r_state == ST_EXEC) && bus.Done;

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_fetch_req   = 1'b0;
    w_instr_ready = 1'b0;
    unique case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_fetch_req = 1'b1;
        if (bus.FetchAck) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_instr_ready = 1'b1;
        if (bus.Done) w_state_nxt = ST_FETCH;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // Next-PC resolution: Ret > Call > Branch > sequential.
  // RedirPC idles at Target so the mux One leg is always defined.
  always_comb begin
    w_pcsrc    = 1'b0;
    w_redir_pc = bus.Target;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_set_ovf  = 1'b0;
    w_set_unf  = 1'b0;
    if (w_exec_done) begin
      if (bus.Ret) begin
        if (!w_empty) begin
          w_redir_pc = w_top;
          w_pcsrc    = 1'b1;
          w_pop      = 1'b1;
        end else begin
          w_set_unf  = 1'b1;
        end
      end else if (bus.Call) begin
        w_pcsrc   = 1'b1;
        w_push    = 1'b1;
        w_set_ovf = w_full;
      end else if (bus.Branch) begin
        w_pcsrc   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VECTOR;
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_exec_done) r_pc <= w_pcsrc ? w_redir_pc : w_seq_pc;
      // A push onto a full stack overwrites the oldest entry: the pointer
      // already sits on it, so only the count saturates.
      if (w_push) begin
        r_sp <= r_sp + SPW'(1);
        if (!w_full) r_count <= r_count + CW'(1);
      end else if (w_pop) begin
        r_sp    <= w_sp_dec;
        r_count <= r_count - CW'(1);
      end
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  // Stack storage carries no reset; validity is tracked by r_count.
  always_ff @(posedge CLK) begin
    if (!Reset && w_push) r_stack[r_sp] <= w_seq_pc;
  end

  assign bus.FetchReq     = w_fetch_req;
  assign bus.FetchAddr    = r_pc;
  assign bus.InstrReady   = w_instr_ready;
  assign bus.PCSrc        = w_pcsrc;
  assign bus.SeqPC        = w_seq_pc;
  assign bus.RedirPC      = w_redir_pc;
  assign bus.PC           = r_pc;
  assign bus.RasOverflow  = r_ovf;
  assign bus.RasUnderflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  logic CLK;
  logic Reset;
  int   vectors;
  int   miscompares;
  logic [15:0] exp_q [$];

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR (16'h0100),
    .PC_INCR      (2),
    .RAS_DEPTH    (4)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Bounded wait for the sequencer to raise FetchReq.
  task automatic wait_fetch();
    for (int i = 0; i < 10; i++) begin
      if (bus.FetchReq === 1'b1) break;
      step();
    end
    check("fetch_wait", {31'd0, bus.FetchReq}, 32'd1);
  endtask

  // One instruction: fetch (with ack_delay idle cycles), then EXEC with Done
  // and the given request lines. Expected next fetch address goes to the
  // scoreboard and is popped at the following fetch.
  task automatic instr(input int delay, input logic r, input logic c, input logic b,
                       input logic [15:0] tgt, input logic exp_src, input logic [15:0] nxt);
    logic [15:0] ea;
    wait_fetch();
    ea = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
    check("fetch_addr", {16'd0, bus.FetchAddr}, {16'd0, ea});
    check("pc", {16'd0, bus.PC}, {16'd0, ea});
    check("seq_pc", {16'd0, bus.SeqPC}, {16'd0, ea + 16'd2});
    for (int i = 0; i < delay; i++) begin
      step();
      check("req_hold", {31'd0, bus.FetchReq}, 32'd1);
      check("addr_hold", {16'd0, bus.FetchAddr}, {16'd0, ea});
      check("pc_hold", {16'd0, bus.PC}, {16'd0, ea});
    end
    bus.FetchAck = 1'b1;
    step();
    bus.FetchAck = 1'b0;
    check("instr_ready", {31'd0, bus.InstrReady}, 32'd1);
    check("req_low_exec", {31'd0, bus.FetchReq}, 32'd0);
    bus.Ret = r; bus.Call = c; bus.Branch = b; bus.Target = tgt; bus.Done = 1'b1;
    #1;
    check("pcsrc", {31'd0, bus.PCSrc}, {31'd0, exp_src});
    if (exp_src) check("redir_pc", {16'd0, bus.RedirPC}, {16'd0, nxt});
    exp_q.push_back(nxt);
    step();
    bus.Done = 1'b0; bus.Ret = 1'b0; bus.Call = 1'b0; bus.Branch = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    Reset = 1'b1;
    bus.FetchAck = 1'b0; bus.Done = 1'b0; bus.Branch = 1'b0;
    bus.Call = 1'b0; bus.Ret = 1'b0; bus.Target = 16'h0000;
    step(); step();
    check("rst_pc", {16'd0, bus.PC}, 32'h0100);
    check("rst_req", {31'd0, bus.FetchReq}, 32'd0);
    check("rst_ready", {31'd0, bus.InstrReady}, 32'd0);
    check("rst_pcsrc", {31'd0, bus.PCSrc}, 32'd0);
    check("rst_ovf", {31'd0, bus.RasOverflow}, 32'd0);
    check("rst_unf", {31'd0, bus.RasUnderflow}, 32'd0);
    Reset = 1'b0;
    exp_q.push_back(16'h0100);

    // Sequential run, then a delayed ack
    instr(0, 0, 0, 0, 16'h1234, 1'b0, 16'h0102);
    instr(0, 0, 0, 0, 16'h1234, 1'b0, 16'h0104);
    instr(3, 0, 0, 0, 16'h1234, 1'b0, 16'h0106);
    // Branch, call / sequential / return
    instr(0, 0, 0, 1, 16'h0200, 1'b1, 16'h0200);
    instr(0, 0, 1, 0, 16'h0400, 1'b1, 16'h0400);
    instr(0, 0, 0, 0, 16'h0000, 1'b0, 16'h0402);
    instr(0, 1, 0, 0, 16'h0000, 1'b1, 16'h0202);
    // Priority: stack holds 0x0300, all three requests asserted
    instr(0, 0, 0, 1, 16'h02FE, 1'b1, 16'h02FE);
    instr(0, 0, 1, 0, 16'h0600, 1'b1, 16'h0600);
    instr(0, 1, 1, 1, 16'h0500, 1'b1, 16'h0300);
    check("prio_unf", {31'd0, bus.RasUnderflow}, 32'd0);
    // Stack must now be empty: Ret falls through and flags underflow
    instr(0, 1, 0, 0, 16'h0700, 1'b0, 16'h0302);
    check("empty_unf", {31'd0, bus.RasUnderflow}, 32'd1);
    check("empty_ovf", {31'd0, bus.RasOverflow}, 32'd0);

    // Reset mid-FETCH
    wait_fetch();
    check("pre_rst_addr", {16'd0, bus.FetchAddr}, {16'd0, exp_q.pop_front()});
    step();
    check("pre_rst_req", {31'd0, bus.FetchReq}, 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("mid_rst_req", {31'd0, bus.FetchReq}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.InstrReady}, 32'd0);
    check("mid_rst_pc", {16'd0, bus.PC}, 32'h0100);
    check("mid_rst_unf", {31'd0, bus.RasUnderflow}, 32'd0);
    check("mid_rst_ovf", {31'd0, bus.RasOverflow}, 32'd0);
    exp_q.push_back(16'h0100);

    // Five nested calls into a depth-4 stack, then five returns
    instr(0, 0, 0, 1, 16'h1000, 1'b1, 16'h1000);
    instr(0, 0, 1, 0, 16'h2000, 1'b1, 16'h2000);
    instr(0, 0, 1, 0, 16'h3000, 1'b1, 16'h3000);
    instr(0, 0, 1, 0, 16'h4000, 1'b1, 16'h4000);
    instr(0, 0, 1, 0, 16'h5000, 1'b1, 16'h5000);
    check("ovf_4calls", {31'd0, bus.RasOverflow}, 32'd0);
    instr(0, 0, 1, 0, 16'h6000, 1'b1, 16'h6000);
    check("ovf_5calls", {31'd0, bus.RasOverflow}, 32'd1);
    instr(0, 1, 0, 0, 16'h0000, 1'b1, 16'h5002);
    instr(0, 1, 0, 0, 16'h0000, 1'b1, 16'h4002);
    instr(0, 1, 0, 0, 16'h0000, 1'b1, 16'h3002);
    instr(0, 1, 0, 0, 16'h0000, 1'b1, 16'h2002);
    check("unf_4rets", {31'd0, bus.RasUnderflow}, 32'd0);
    instr(0, 1, 0, 0, 16'h0000, 1'b0, 16'h2004);
    check("unf_5rets", {31'd0, bus.RasUnderflow}, 32'd1);
    check("ovf_sticky", {31'd0, bus.RasOverflow}, 32'd1);

    // PC wrap at the top of the address space
    instr(0, 0, 0, 1, 16'hFFFE, 1'b1, 16'hFFFE);
    instr(0, 0, 0, 0, 16'h1111, 1'b0, 16'h0000);
    wait_fetch();
    check("wrap_addr", {16'd0, bus.FetchAddr}, {16'd0, exp_q.pop_front()});
    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
